// File: rtl/vga_timing_pkg.sv
// Shared timing defaults and helpers for the VGA timing generator.
package vga_timing_pkg;

  // 640x480 @ 60 Hz (25.175 MHz pixel clock) timing, in pixels / lines
  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  // Period of one axis: display + front porch + sync + back porch
  function automatic int axis_total(input int display, input int front,
                                    input int sync, input int back);
    return display + front + sync + back;
  endfunction

  // Smallest counter width able to hold the values 0..n-1
  function automatic int min_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus registered sync and
// next-state visible flag. Used once for columns and once for lines.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int DISPLAY = DEF_H_DISPLAY,
  parameter int FRONT   = DEF_H_FRONT,
  parameter int SYNC    = DEF_H_SYNC,
  parameter int BACK    = DEF_H_BACK,
  parameter bit POL     = 1'b0,
  parameter int CNT_W   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             active_next,
  output logic             sync
);

  localparam int TOTAL = axis_total(DISPLAY, FRONT, SYNC, BACK);

  // Bounds are one bit wider than the counter so a window ending exactly
  // at 2**CNT_W does not truncate to zero.
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W:0]   DISP_E  = (CNT_W+1)'(DISPLAY);
  localparam logic [CNT_W:0]   SYNC_LO = (CNT_W+1)'(DISPLAY + FRONT);
  localparam logic [CNT_W:0]   SYNC_HI = (CNT_W+1)'(DISPLAY + FRONT + SYNC);

  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W:0]   cnt_ext;
  logic             sync_nxt;

  // wrap marks the last position; the owner qualifies it with its advance
  assign wrap = (cnt == LAST);

  // Next-state position and the decodes derived from it, so the registered
  // sync lines up with the counter on the same edge.
  always_comb begin
    cnt_nxt = cnt;
    if (inc) cnt_nxt = wrap ? '0 : cnt + 1'b1;
    cnt_ext     = {1'b0, cnt_nxt};
    active_next = (cnt_ext < DISP_E);
    sync_nxt    = ((cnt_ext >= SYNC_LO) && (cnt_ext < SYNC_HI)) ? POL : ~POL;
  end

  // Reset parks the axis at its last back-porch position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= LAST;
      sync <= ~POL;
    end else begin
      cnt  <= cnt_nxt;
      sync <= sync_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-rate divider, horizontal and
// vertical axis counters, registered sync / blanking / coordinates / markers.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY  = DEF_H_DISPLAY,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_DISPLAY  = DEF_V_DISPLAY,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int CLK_DIV    = 4,
  parameter int CNT_W      = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic             pix_tick,
  output logic             h_sync,
  output logic             v_sync,
  output logic             video_on,
  output logic [CNT_W-1:0] x_loc,
  output logic [CNT_W-1:0] y_loc,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = axis_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // Reject configurations the counters cannot represent
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end
  if (CNT_W < min_width(H_TOTAL)) begin : g_bad_hw
    $error("vga_timing_gen: CNT_W too narrow for H_TOTAL");
  end
  if (CNT_W < min_width(V_TOTAL)) begin : g_bad_vw
    $error("vga_timing_gen: CNT_W too narrow for V_TOTAL");
  end

  logic [DIV_W-1:0] div;
  logic             tick;
  logic             h_wrap, v_wrap;
  logic             h_act_nxt, v_act_nxt;
  logic [CNT_W-1:0] h_cnt, v_cnt;

  // Advance strobe: last system clock of the current pixel while running
  assign tick = enable && (div == DIV_LAST);

  // Pixel divider; pausing parks it at 0 so a resume waits a full pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                div <= '0;
    else if (!enable || tick)  div <= '0;
    else                       div <= div + 1'b1;
  end

  vga_axis_counter #(
    .DISPLAY(H_DISPLAY), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
    .POL(H_SYNC_POL), .CNT_W(CNT_W)
  ) u_h (
    .clk(clk), .rst_n(rst_n), .inc(tick),
    .cnt(h_cnt), .wrap(h_wrap), .active_next(h_act_nxt), .sync(h_sync)
  );

  // Lines advance on the same edge the column counter wraps to 0
  vga_axis_counter #(
    .DISPLAY(V_DISPLAY), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
    .POL(V_SYNC_POL), .CNT_W(CNT_W)
  ) u_v (
    .clk(clk), .rst_n(rst_n), .inc(tick && h_wrap),
    .cnt(v_cnt), .wrap(v_wrap), .active_next(v_act_nxt), .sync(v_sync)
  );

  // Pulses and blanking registered from next state so they align with x/y
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_tick    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      video_on    <= 1'b0;
    end else begin
      pix_tick    <= tick;
      line_start  <= tick && h_wrap;
      frame_start <= tick && h_wrap && v_wrap;
      video_on    <= h_act_nxt && v_act_nxt;
    end
  end

  assign x_loc = h_cnt;
  assign y_loc = v_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a per-cycle vector table for the CLK_DIV=4 raster start
// and pause behaviour, plus hand sequences for line, frame and reset cases.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en4 = 1'b1, en1 = 1'b1, ens = 1'b1;

  always #5 clk = ~clk;

  // 640x480 defaults at CLK_DIV=4
  logic p4, hs4, vs4, vo4, ls4, fs4;
  logic [9:0] x4, y4;
  // 640x480 defaults at CLK_DIV=1
  logic p1, hs1, vs1, vo1, ls1, fs1;
  logic [9:0] x1, y1;
  // Small 16x10 raster, CLK_DIV=2, active-high syncs
  logic ps, hss, vss, vos, lss, fss;
  logic [9:0] xs, ys;

  vga_timing_gen #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable(en4), .pix_tick(p4), .h_sync(hs4),
    .v_sync(vs4), .video_on(vo4), .x_loc(x4), .y_loc(y4),
    .line_start(ls4), .frame_start(fs4));

  vga_timing_gen #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(en1), .pix_tick(p1), .h_sync(hs1),
    .v_sync(vs1), .video_on(vo1), .x_loc(x1), .y_loc(y1),
    .line_start(ls1), .frame_start(fs1));

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CLK_DIV(2), .CNT_W(10)
  ) dsm (
    .clk(clk), .rst_n(rst_n), .enable(ens), .pix_tick(ps), .h_sync(hss),
    .v_sync(vss), .video_on(vos), .x_loc(xs), .y_loc(ys),
    .line_start(lss), .frame_start(fss));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic rst_n, en;
    int   x, y;
    logic pix, vid, hs, vs, ls, fs;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(input logic r, input logic e, input int x,
                              input int y, input logic p, input logic v,
                              input logic hs, input logic vs,
                              input logic ls, input logic fs);
    vec_t t;
    t.rst_n = r; t.en = e; t.x = x; t.y = y; t.pix = p; t.vid = v;
    t.hs = hs; t.vs = vs; t.ls = ls; t.fs = fs;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ok, bad, ysnap, px, vf, hf, hr, per, lsc, vmin, vmax, hmin, hmax, voc;
    logic pv, ph;

    // Vector table for dut4: reset, first pixel, pause at divider 0 and 2
    for (int i = 0; i < 2; i++)  tbl[i] = mk(0,1,799,524,0,0,1,1,0,0);
    for (int i = 2; i < 5; i++)  tbl[i] = mk(1,1,799,524,0,0,1,1,0,0);
    tbl[5] = mk(1,1,0,0,1,1,1,1,1,1);
    for (int i = 6; i < 9; i++)  tbl[i] = mk(1,1,0,0,0,1,1,1,0,0);
    tbl[9] = mk(1,1,1,0,1,1,1,1,0,0);
    for (int i = 10; i < 12; i++) tbl[i] = mk(1,0,1,0,0,1,1,1,0,0);
    for (int i = 12; i < 15; i++) tbl[i] = mk(1,1,1,0,0,1,1,1,0,0);
    tbl[15] = mk(1,1,2,0,1,1,1,1,0,0);
    for (int i = 16; i < 18; i++) tbl[i] = mk(1,1,2,0,0,1,1,1,0,0);
    for (int i = 18; i < 20; i++) tbl[i] = mk(1,0,2,0,0,1,1,1,0,0);
    for (int i = 20; i < 23; i++) tbl[i] = mk(1,1,2,0,0,1,1,1,0,0);
    tbl[23] = mk(1,1,3,0,1,1,1,1,0,0);

    // Reset levels of the inverted-polarity instance
    step();
    chk("sm_rst_x", xs, 15);
    chk("sm_rst_y", ys, 9);
    chk("sm_rst_hs", hss, 0);
    chk("sm_rst_vs", vss, 0);
    chk("sm_rst_vid", vos, 0);

    for (int i = 0; i < 24; i++) begin
      rst_n = tbl[i].rst_n;
      en4   = tbl[i].en;
      step();
      chk($sformatf("v%0d.x", i),   x4,  tbl[i].x);
      chk($sformatf("v%0d.y", i),   y4,  tbl[i].y);
      chk($sformatf("v%0d.pix", i), p4,  tbl[i].pix);
      chk($sformatf("v%0d.vid", i), vo4, tbl[i].vid);
      chk($sformatf("v%0d.hs", i),  hs4, tbl[i].hs);
      chk($sformatf("v%0d.vs", i),  vs4, tbl[i].vs);
      chk($sformatf("v%0d.ls", i),  ls4, tbl[i].ls);
      chk($sformatf("v%0d.fs", i),  fs4, tbl[i].fs);
    end

    // Pause dut1 at x=300 for 50 clocks
    ok = 0;
    for (int i = 0; i < 1000 && ok == 0; i++) begin
      step();
      if (x1 == 10'd300) ok = 1;
    end
    chk("wait_x300", ok, 1);
    en1 = 1'b0;
    ysnap = int'(y1);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (x1 !== 10'd300 || p1 !== 1'b0 || hs1 !== 1'b1 || int'(y1) != ysnap
          || vo1 !== (ysnap < 480) || ls1 !== 1'b0)
        bad++;
    end
    chk("pause_hold", bad, 0);
    en1 = 1'b1;
    step();
    chk("resume_x", x1, 301);
    chk("resume_pix", p1, 1);

    // One line at CLK_DIV=1
    ok = 0;
    for (int i = 0; i < 1000 && ok == 0; i++) begin
      step();
      if (x1 == 10'd0) ok = 1;
    end
    chk("wait_x0", ok, 1);
    chk("x0_line_start", ls1, 1);
    px = int'(x1); pv = vo1; ph = hs1;
    vf = -1; hf = -1; hr = -1; per = 0; bad = 0;
    for (int i = 1; i <= 800; i++) begin
      step();
      if (int'(x1) != (px + 1) % 800) bad++;
      if (pv && !vo1 && vf < 0) vf = int'(x1);
      if (ph && !hs1 && hf < 0) hf = int'(x1);
      if (!ph && hs1 && hr < 0) hr = int'(x1);
      if (ls1 && per == 0) per = i;
      px = int'(x1); pv = vo1; ph = hs1;
    end
    chk("x_sequence", bad, 0);
    chk("video_off_x", vf, 640);
    chk("hsync_low_x", hf, 656);
    chk("hsync_high_x", hr, 752);
    chk("line_period", per, 800);

    // Full frame on the small raster (16 px x 10 lines x 2 clk = 320 clk)
    ok = 0;
    for (int i = 0; i < 400 && ok == 0; i++) begin
      step();
      if (fss) ok = 1;
    end
    chk("wait_frame", ok, 1);
    per = 0; lsc = 0; bad = 0; voc = 0;
    vmin = 99; vmax = -1; hmin = 99; hmax = -1;
    for (int i = 1; i <= 400 && per == 0; i++) begin
      step();
      if (lss) lsc++;
      if (fss && (xs != 10'd0 || ys != 10'd0)) bad++;
      if (lss && ys == 10'd0 && !fss) bad++;
      if (fss && !lss) bad++;
      if (vss) begin
        if (int'(ys) < vmin) vmin = int'(ys);
        if (int'(ys) > vmax) vmax = int'(ys);
      end
      if (hss) begin
        if (int'(xs) < hmin) hmin = int'(xs);
        if (int'(xs) > hmax) hmax = int'(xs);
      end
      if (vos) voc++;
      if (fss) per = i;
    end
    chk("frame_period", per, 320);
    chk("lines_per_frame", lsc, 10);
    chk("frame_start_only_00", bad, 0);
    chk("vsync_first_y", vmin, 7);
    chk("vsync_last_y", vmax, 8);
    chk("hsync_first_x", hmin, 10);
    chk("hsync_last_x", hmax, 12);
    chk("visible_clks", voc, 96);

    // Asynchronous reset in the middle of line 5
    ok = 0;
    for (int i = 0; i < 400 && ok == 0; i++) begin
      step();
      if (ys == 10'd5 && xs == 10'd3) ok = 1;
    end
    chk("wait_y5", ok, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_x", xs, 15);
    chk("mid_rst_y", ys, 9);
    chk("mid_rst_vid", vos, 0);
    chk("mid_rst_hs", hss, 0);
    chk("mid_rst_vs", vss, 0);
    chk("mid_rst_dut1_x", x1, 799);
    chk("mid_rst_dut1_y", y1, 524);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (ps | lss | fss | p1 | ls1 | fs1 | p4 | ls4 | fs4) bad++;
    end
    chk("rst_no_pulses", bad, 0);
    rst_n = 1'b1;
    step();
    chk("rel1_x", xs, 15);
    chk("rel1_pix", ps, 0);
    step();
    chk("rel2_x", xs, 0);
    chk("rel2_y", ys, 0);
    chk("rel2_fs", fss, 1);
    chk("rel2_vid", vos, 1);
    step();
    chk("rel3_fs", fss, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
